// File: rtl/l2_request_arbiter_pkg.sv
// l2_request_arbiter_pkg: shared widths, queue record types and word-count rule for the L2 request arbiter
package l2_request_arbiter_pkg;

    localparam int L2_NUM_PORTS = 2;
    localparam int L2_ID_W      = (L2_NUM_PORTS > 1) ? $clog2(L2_NUM_PORTS) : 1;

    typedef struct packed {
        logic [29:0]        addr;
        logic               rnw;
        logic               is_amo;
        logic [4:0]         amo_type_or_burst_size;
        logic [L2_ID_W-1:0] id;
    } l2_arb_request_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
    } l2_wdata_t;

    // Data words a request carries: write = burst+1, AMO = 1 operand, read = none.
    function automatic logic [5:0] l2_word_count(input logic rnw, input logic is_amo, input logic [4:0] burst);
        return is_amo ? 6'd1 : rnw ? 6'd0 : {1'b0, burst} + 6'd1;
    endfunction

endpackage

// File: rtl/l2_sync_fifo.sv
// l2_sync_fifo: synchronous FIFO with registered occupancy count and LUTRAM storage
//   clk, rst_n     clock, synchronous active-low reset (empties the queue)
//   push, wdata    write strobe and word; ignored when full unless a pop happens the same cycle
//   pop, rdata     read strobe and head word; pop ignored when empty
//   empty, count   empty flag and number of stored words
module l2_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      pop,
    output logic [DATA_W-1:0]         rdata,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = CW'(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic full, do_push, do_pop;
    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: round-robin arbiter queueing L1 requests and write data toward the L2/AXI bridge
//   clk, rst_n                     clock, synchronous active-low reset
//   req_*                          per-port request (valid/ready, addr, rnw, is_amo, fn5/burst)
//   req_wdata*                     per-port write data words (valid/ready handshake)
//   rsp_rd_data, rsp_rd_valid      read data broadcast, per-port valid routed by l2_rd_id
//   rsp_wr_done                    per-port write/AMO completion, returned in issue order
//   l2_*                           master side of the memory interface (request, write data, responses)
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int NUM_PORTS        = L2_NUM_PORTS,
    parameter int REQ_FIFO_DEPTH   = 4,
    parameter int WDATA_FIFO_DEPTH = 32,
    parameter int WORDER_DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_PORTS-1:0]   req_valid,
    output logic [NUM_PORTS-1:0]   req_ready,
    input  logic [NUM_PORTS*30-1:0] req_addr,
    input  logic [NUM_PORTS-1:0]   req_rnw,
    input  logic [NUM_PORTS-1:0]   req_is_amo,
    input  logic [NUM_PORTS*5-1:0] req_amo_type_or_burst_size,
    input  logic [NUM_PORTS*32-1:0] req_wdata,
    input  logic [NUM_PORTS*4-1:0] req_wdata_be,
    input  logic [NUM_PORTS-1:0]   req_wdata_valid,
    output logic [NUM_PORTS-1:0]   req_wdata_ready,
    output logic [31:0]            rsp_rd_data,
    output logic [NUM_PORTS-1:0]   rsp_rd_valid,
    output logic [NUM_PORTS-1:0]   rsp_wr_done,
    output logic                   l2_request_valid,
    input  logic                   l2_request_pop,
    output logic [29:0]            l2_addr,
    output logic                   l2_rnw,
    output logic                   l2_is_amo,
    output logic [4:0]             l2_amo_type_or_burst_size,
    output logic [L2_ID_W-1:0]     l2_id,
    output logic [31:0]            l2_wr_data,
    output logic [3:0]             l2_wr_data_be,
    output logic                   l2_wr_data_valid,
    input  logic                   l2_wr_data_read,
    input  logic [31:0]            l2_rd_data,
    input  logic [L2_ID_W-1:0]     l2_rd_id,
    input  logic                   l2_rd_data_valid,
    input  logic                   l2_wr_complete
);
    logic [NUM_PORTS-1:0][29:0] addr_v;
    logic [NUM_PORTS-1:0][4:0]  burst_v;
    logic [NUM_PORTS-1:0][31:0] wdata_v;
    logic [NUM_PORTS-1:0][3:0]  be_v;
    logic [NUM_PORTS-1:0][5:0]  words;
    logic [NUM_PORTS-1:0]       eligible;
    l2_arb_request_t rq_in, rq_head;
    l2_wdata_t wq_in, wq_head;
    logic [L2_ID_W-1:0] ptr, gnt_id, idx, cap_port, oq_head;
    logic [$clog2(REQ_FIFO_DEPTH):0] rq_count;
    logic [$clog2(WDATA_FIFO_DEPTH):0] wq_count;
    logic [$clog2(WORDER_DEPTH):0] oq_count;
    logic rq_empty, wq_empty, oq_empty, rq_full, wq_full, oq_full;
    logic gnt, data_gnt, cap_active, wq_push, oq_pop;
    logic [5:0] cap_left;

    assign addr_v  = req_addr;
    assign burst_v = req_amo_type_or_burst_size;
    assign wdata_v = req_wdata;
    assign be_v    = req_wdata_be;
    assign rq_full = int'(rq_count) == REQ_FIFO_DEPTH;
    assign wq_full = int'(wq_count) == WDATA_FIFO_DEPTH;
    assign oq_full = int'(oq_count) == WORDER_DEPTH;

    // Reads only need a reqQ slot; data requests also need the capture engine and room for every word.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            words[p]    = l2_word_count(req_rnw[p], req_is_amo[p], burst_v[p]);
            eligible[p] = req_valid[p] & ~rq_full & ((words[p] == 6'd0) |
                          (~cap_active & ~oq_full & (WDATA_FIFO_DEPTH - int'(wq_count) >= int'(words[p]))));
        end
    end

    // Scan from the far end back toward ptr so the eligible port closest to ptr wins.
    always_comb begin
        gnt    = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = L2_ID_W'((int'(ptr) + i) % NUM_PORTS);
            if (rst_n && eligible[idx]) begin
                gnt    = 1'b1;
                gnt_id = idx;
            end
        end
    end

    assign data_gnt        = gnt & (words[gnt_id] != 6'd0);
    assign req_ready       = gnt ? NUM_PORTS'(1) << gnt_id : '0;
    assign req_wdata_ready = (rst_n & cap_active & ~wq_full) ? NUM_PORTS'(1) << cap_port : '0;
    assign wq_push         = |(req_wdata_ready & req_wdata_valid);
    assign rq_in           = '{addr: addr_v[gnt_id], rnw: req_rnw[gnt_id], is_amo: req_is_amo[gnt_id],
                               amo_type_or_burst_size: burst_v[gnt_id], id: gnt_id};
    assign wq_in           = '{data: wdata_v[cap_port], be: be_v[cap_port]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= '0;
            cap_active <= 1'b0;
            cap_port   <= '0;
            cap_left   <= '0;
        end else begin
            if (gnt) ptr <= (int'(gnt_id) == NUM_PORTS - 1) ? '0 : gnt_id + 1'b1;
            if (data_gnt) begin
                cap_active <= 1'b1;
                cap_port   <= gnt_id;
                cap_left   <= words[gnt_id];
            end else if (wq_push) begin
                cap_left   <= cap_left - 6'd1;
                cap_active <= cap_left != 6'd1;
            end
        end
    end

    l2_sync_fifo #(.DATA_W($bits(l2_arb_request_t)), .DEPTH(REQ_FIFO_DEPTH)) u_req_q (
        .clk(clk), .rst_n(rst_n), .push(gnt), .wdata(rq_in), .pop(l2_request_pop),
        .rdata(rq_head), .empty(rq_empty), .count(rq_count));

    l2_sync_fifo #(.DATA_W($bits(l2_wdata_t)), .DEPTH(WDATA_FIFO_DEPTH)) u_wdata_q (
        .clk(clk), .rst_n(rst_n), .push(wq_push), .wdata(wq_in), .pop(l2_wr_data_read),
        .rdata(wq_head), .empty(wq_empty), .count(wq_count));

    l2_sync_fifo #(.DATA_W(L2_ID_W), .DEPTH(WORDER_DEPTH)) u_order_q (
        .clk(clk), .rst_n(rst_n), .push(data_gnt), .wdata(gnt_id), .pop(oq_pop),
        .rdata(oq_head), .empty(oq_empty), .count(oq_count));

    assign l2_request_valid          = ~rq_empty;
    assign l2_addr                   = rq_head.addr;
    assign l2_rnw                    = rq_head.rnw;
    assign l2_is_amo                 = rq_head.is_amo;
    assign l2_amo_type_or_burst_size = rq_head.amo_type_or_burst_size;
    assign l2_id                     = rq_head.id;
    assign l2_wr_data_valid          = ~wq_empty;
    assign l2_wr_data                = wq_head.data;
    assign l2_wr_data_be             = wq_head.be;
    assign oq_pop                    = l2_wr_complete & ~oq_empty;
    assign rsp_wr_done               = oq_pop ? NUM_PORTS'(1) << oq_head : '0;
    assign rsp_rd_data               = l2_rd_data;
    assign rsp_rd_valid              = l2_rd_data_valid ? NUM_PORTS'(1) << l2_rd_id : '0;

    // A completion with nothing outstanding is dropped; flag it in simulation.
    always_ff @(posedge clk)
        if (rst_n && l2_wr_complete) assert (!oq_empty);
endmodule

// File: tb/tb_l2_request_arbiter.sv
// tb_l2_request_arbiter: randomized scoreboard bench for the L2 request arbiter
module tb_l2_request_arbiter;
    import l2_request_arbiter_pkg::*;
    localparam int NP  = L2_NUM_PORTS;
    localparam int RQD = 4;
    localparam int WQD = 32;
    localparam int OQD = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [NP-1:0]    req_valid, req_ready, req_rnw, req_is_amo, req_wdata_valid, req_wdata_ready;
    logic [NP*30-1:0] req_addr;
    logic [NP*5-1:0]  req_amo_type_or_burst_size;
    logic [NP*32-1:0] req_wdata;
    logic [NP*4-1:0]  req_wdata_be;
    logic [31:0]      rsp_rd_data;
    logic [NP-1:0]    rsp_rd_valid, rsp_wr_done;
    logic             l2_request_valid, l2_request_pop, l2_rnw, l2_is_amo;
    logic [29:0]      l2_addr;
    logic [4:0]       l2_amo_type_or_burst_size;
    logic [L2_ID_W-1:0] l2_id, l2_rd_id;
    logic [31:0]      l2_wr_data, l2_rd_data;
    logic [3:0]       l2_wr_data_be;
    logic             l2_wr_data_valid, l2_wr_data_read, l2_rd_data_valid, l2_wr_complete;

    always #5 clk = ~clk;

    l2_request_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_rnw(req_rnw),
        .req_is_amo(req_is_amo), .req_amo_type_or_burst_size(req_amo_type_or_burst_size),
        .req_wdata(req_wdata), .req_wdata_be(req_wdata_be), .req_wdata_valid(req_wdata_valid),
        .req_wdata_ready(req_wdata_ready), .rsp_rd_data(rsp_rd_data), .rsp_rd_valid(rsp_rd_valid),
        .rsp_wr_done(rsp_wr_done), .l2_request_valid(l2_request_valid), .l2_request_pop(l2_request_pop),
        .l2_addr(l2_addr), .l2_rnw(l2_rnw), .l2_is_amo(l2_is_amo),
        .l2_amo_type_or_burst_size(l2_amo_type_or_burst_size), .l2_id(l2_id),
        .l2_wr_data(l2_wr_data), .l2_wr_data_be(l2_wr_data_be), .l2_wr_data_valid(l2_wr_data_valid),
        .l2_wr_data_read(l2_wr_data_read), .l2_rd_data(l2_rd_data), .l2_rd_id(l2_rd_id),
        .l2_rd_data_valid(l2_rd_data_valid), .l2_wr_complete(l2_wr_complete));

    int n_cmp = 0;
    int n_bad = 0;
    // Reference model: queue occupancies, RR pointer and the words still owed by the active capture.
    int rq_cnt, wq_cnt, oq_cnt, ptr, cap_port, owed, req_pct, pop_pct;
    logic [35:0] cap_data[$];
    logic [35:0] exp_wd[$];
    l2_arb_request_t exp_req[$];
    int exp_order[$];
    logic [L2_ID_W-1:0] rd_beats[$];
    logic pend [NP];
    logic [29:0] p_addr [NP];
    logic p_rnw [NP];
    logic p_amo [NP];
    logic [4:0] p_b [NP];

    function automatic int nwords(int p);
        return p_amo[p] ? 1 : p_rnw[p] ? 0 : int'(p_b[p]) + 1;
    endfunction

    function automatic bit any_pend();
        for (int p = 0; p < NP; p++) if (pend[p]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (!pend[p] && int'($urandom_range(99)) < req_pct) begin
                int k;
                k = int'($urandom_range(9));
                pend[p]   = 1'b1;
                p_addr[p] = 30'($urandom);
                p_amo[p]  = k >= 8;
                p_rnw[p]  = k < 5 || k >= 8;
                p_b[p]    = (k < 5) ? 5'($urandom_range(15)) : 5'($urandom_range(31));
            end
            req_valid[p]                     = pend[p];
            req_addr[p*30 +: 30]             = p_addr[p];
            req_rnw[p]                       = p_rnw[p];
            req_is_amo[p]                    = p_amo[p];
            req_amo_type_or_burst_size[p*5 +: 5] = p_b[p];
            req_wdata[p*32 +: 32]            = $urandom;
            req_wdata_be[p*4 +: 4]           = 4'($urandom);
            req_wdata_valid[p]               = rst_n && (cap_data.size() == 0 || p != cap_port) &&
                                               $urandom_range(99) < 20;
        end
        if (rst_n && cap_data.size() > 0) begin
            req_wdata_valid[cap_port]        = $urandom_range(99) < 70;
            req_wdata[cap_port*32 +: 32]     = cap_data[0][35:4];
            req_wdata_be[cap_port*4 +: 4]    = cap_data[0][3:0];
        end
        l2_request_pop   = rst_n && rq_cnt > 0 && int'($urandom_range(99)) < pop_pct;
        l2_wr_data_read  = rst_n && $urandom_range(99) < 60;
        l2_wr_complete   = rst_n && owed > 0 && $urandom_range(99) < 30;
        l2_rd_data_valid = rst_n && rd_beats.size() > 0 && $urandom_range(99) < 70;
        l2_rd_id         = l2_rd_data_valid ? rd_beats[0] : '0;
        l2_rd_data       = $urandom;
    endtask

    task automatic step(input logic rst_v);
        @(posedge clk);
        #1;
        rst_n = rst_v;
        drive();
    endtask

    // Monitor and model: outputs are compared before the model advances past the coming edge.
    always @(negedge clk) begin : mon
        int eg, q;
        logic acc, rq_pop, wq_pop, oq_pop;
        logic [35:0] d;
        eg = -1;
        if (rst_n)
            for (int i = 0; i < NP; i++) begin
                q = (ptr + i) % NP;
                if (eg < 0 && pend[q] && rq_cnt < RQD &&
                    (nwords(q) == 0 || (cap_data.size() == 0 && oq_cnt < OQD && WQD - wq_cnt >= nwords(q))))
                    eg = q;
            end
        check("req_ready", 64'(req_ready), (eg >= 0) ? 64'd1 << eg : 64'd0);
        check("req_wdata_ready", 64'(req_wdata_ready),
              (rst_n && cap_data.size() > 0 && wq_cnt < WQD) ? 64'd1 << cap_port : 64'd0);
        check("l2_request_valid", 64'(l2_request_valid), 64'(rq_cnt > 0));
        check("l2_wr_data_valid", 64'(l2_wr_data_valid), 64'(wq_cnt > 0));
        check("rsp_rd_valid", 64'(rsp_rd_valid), l2_rd_data_valid ? 64'd1 << l2_rd_id : 64'd0);
        if (l2_rd_data_valid) check("rsp_rd_data", 64'(rsp_rd_data), 64'(l2_rd_data));
        check("rsp_wr_done", 64'(rsp_wr_done),
              (l2_wr_complete && exp_order.size() > 0) ? 64'd1 << exp_order[0] : 64'd0);
        acc    = rst_n && cap_data.size() > 0 && wq_cnt < WQD && req_wdata_valid[cap_port];
        rq_pop = rst_n && l2_request_pop && rq_cnt > 0;
        wq_pop = rst_n && l2_wr_data_read && wq_cnt > 0;
        oq_pop = rst_n && l2_wr_complete && oq_cnt > 0;
        if (rq_pop) begin
            check("l2_request", 64'({l2_addr, l2_rnw, l2_is_amo, l2_amo_type_or_burst_size, l2_id}),
                  64'(exp_req[0]));
            if (exp_req[0].rnw && !exp_req[0].is_amo)
                for (int b = 0; b <= int'(exp_req[0].amo_type_or_burst_size); b++) rd_beats.push_back(exp_req[0].id);
            else
                owed++;
            void'(exp_req.pop_front());
        end
        if (wq_pop) begin
            check("l2_wr_data", 64'({l2_wr_data, l2_wr_data_be}), 64'(exp_wd[0]));
            void'(exp_wd.pop_front());
        end
        if (!rst_n) begin
            rq_cnt = 0; wq_cnt = 0; oq_cnt = 0; ptr = 0; owed = 0;
            cap_data.delete(); exp_wd.delete(); exp_req.delete(); exp_order.delete(); rd_beats.delete();
        end else begin
            if (l2_rd_data_valid) void'(rd_beats.pop_front());
            if (acc) begin void'(cap_data.pop_front()); wq_cnt++; end
            if (wq_pop) wq_cnt--;
            if (rq_pop) rq_cnt--;
            if (oq_pop) begin oq_cnt--; owed--; void'(exp_order.pop_front()); end
            if (eg >= 0) begin
                exp_req.push_back('{addr: p_addr[eg], rnw: p_rnw[eg], is_amo: p_amo[eg],
                                    amo_type_or_burst_size: p_b[eg], id: L2_ID_W'(eg)});
                rq_cnt++;
                ptr = (eg + 1) % NP;
                if (nwords(eg) > 0) begin
                    oq_cnt++;
                    exp_order.push_back(eg);
                    cap_port = eg;
                    for (int w = 0; w < nwords(eg); w++) begin
                        d = {$urandom, 4'($urandom)};
                        cap_data.push_back(d);
                        exp_wd.push_back(d);
                    end
                end
                pend[eg] = 1'b0;
            end
        end
    end

    initial begin
        int w;
        rst_n = 1'b0;
        rq_cnt = 0; wq_cnt = 0; oq_cnt = 0; ptr = 0; cap_port = 0; owed = 0;
        req_pct = 0; pop_pct = 0;
        for (int p = 0; p < NP; p++) begin
            pend[p] = 1'b0; p_addr[p] = '0; p_rnw[p] = 1'b1; p_amo[p] = 1'b0; p_b[p] = '0;
        end
        drive();
        repeat (2) step(1'b0);
        req_pct = 30; pop_pct = 70;
        repeat (1500) step(1'b1);
        req_pct = 100; pop_pct = 10;
        repeat (1500) step(1'b1);
        req_pct = 100; pop_pct = 50;
        w = 0;
        while (cap_data.size() < 3 && w < 3000) begin step(1'b1); w++; end
        n_cmp++;
        if (w == 3000) begin
            n_bad++;
            $display("FAIL reset_mid_capture: no capture with pending words within %0d cycles", w);
        end
        step(1'b0);
        req_pct = 40; pop_pct = 60;
        repeat (1500) step(1'b1);
        req_pct = 0; pop_pct = 100;
        w = 0;
        while ((rq_cnt | wq_cnt | oq_cnt | owed) != 0 || rd_beats.size() > 0 || cap_data.size() > 0 ||
               any_pend()) begin
            if (w == 3000) break;
            step(1'b1);
            w++;
        end
        n_cmp++;
        if (w == 3000) begin
            n_bad++;
            $display("FAIL drain: traffic still outstanding after %0d cycles", w);
        end
        repeat (2) step(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
